lanzones_fetch: RTL and testbench

- Instruction fetch front-end that sits directly upstream of the lanzones core.
- Generates sequential PCs and issues read requests to the instruction-memory bus, which may have variable latency.
- Buffers the returned words in a small prefetch FIFO and presents them to the core's instruction port with a valid/ready handshake.
- Supports a redirect (jump/branch target) that flushes buffered and in-flight instructions.

---
 rtl/lanzones_pkg.sv | 24 ++
 rtl/lanzones_sync_fifo.sv | 60 ++++++
 rtl/lanzones_fetch.sv | 170 +++++++++++++++++
 tb/tb_lanzones_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lanzones_pkg.sv
// Shared types and constants for the lanzones fetch front-end.
package lanzones_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } fetch_state_e;

    // One prefetch buffer entry: the PC travels with the word it fetched.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/lanzones_sync_fifo.sv
// Registered synchronous FIFO with flush; the head entry is always presented on rdata.
module lanzones_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Drive zero when empty so the consumer never sees stale data.
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full && !clear));

endmodule

// File: rtl/lanzones_fetch.sv
// Instruction fetch front-end: credit-limited sequential fetch, prefetch buffer and
// redirect handling that drops every word still in flight when the target changes.
module lanzones_fetch
    import lanzones_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            redir,
    input  logic [XLEN-1:0] redir_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [ILEN-1:0] mem_rdata,
    output logic            RVld,
    output logic [ILEN-1:0] RData,
    output logic [XLEN-1:0] RPc,
    input  logic            RRdy,
    output logic            busy
);

    localparam int unsigned     CW       = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;             // address of the next new request
    logic [XLEN-1:0] req_addr_q, req_addr_d; // address held while a request waits for grant
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic            pend_q, pend_d;
    logic            stale_q, stale_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            raise;
    logic            grant;
    logic            stale_grant;
    logic            drop_hit;
    logic            credit_ok;
    logic [CW:0]     inflight_sum;
    logic [XLEN-1:0] target;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_rdata;

    assign target       = align_pc(redir_pc);
    assign inflight_sum = {1'b0, fifo_count} + {1'b0, out_q};
    assign credit_ok    = (inflight_sum < (CW + 1)'(DEPTH));

    // A waiting request is never withdrawn, so pend_q alone keeps mem_req up.
    assign raise    = (state_q == RUN) && en && !pend_q && credit_ok;
    assign mem_req  = pend_q | raise;
    assign mem_addr = pend_q ? req_addr_q : pc_q;
    assign grant    = mem_req & mem_gnt;

    // A request that was still waiting when a redirect hit belongs to the old stream.
    assign stale_grant = pend_q & stale_q & mem_gnt;
    assign drop_hit    = mem_rvalid & (drop_q != '0);

    assign fifo_push  = mem_rvalid & (drop_q == '0) & ~redir;
    assign fifo_pop   = RVld & RRdy & ~redir;
    assign fifo_wdata = '{pc: resp_pc_q, instr: mem_rdata};

    assign RVld  = ~fifo_empty;
    assign RData = fifo_rdata.instr;
    assign RPc   = fifo_rdata.pc;
    assign busy  = (out_q != '0) || (drop_q != '0);

    lanzones_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .clear (redir),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        pend_d     = mem_req & ~mem_gnt;
        stale_d    = pend_d & (stale_q | redir);
        req_addr_d = (raise && !mem_gnt) ? pc_q : req_addr_q;
        out_d      = out_q + CW'(grant) - CW'(mem_rvalid);
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q - CW'(drop_hit) + CW'(stale_grant);

        if (raise) begin
            pc_d = pc_q + PC_STEP;
        end
        if (fifo_push) begin
            resp_pc_d = resp_pc_q + PC_STEP;
        end
        // Everything in flight after this cycle belongs to the abandoned stream.
        if (redir) begin
            pc_d      = target;
            resp_pc_d = target;
            drop_d    = out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en && !mem_req) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (drop_d == '0 && !stale_d) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redir && (out_d != '0 || stale_d)) begin
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= START_PC;
            req_addr_q <= START_PC;
            resp_pc_q  <= START_PC;
            pend_q     <= 1'b0;
            stale_q    <= 1'b0;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            resp_pc_q  <= resp_pc_d;
            pend_q     <= pend_d;
            stale_q    <= stale_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    a_out_bound  : assert property (@(posedge clk) disable iff (rst) out_q <= CW'(DEPTH));
    a_drop_bound : assert property (@(posedge clk) disable iff (rst) drop_q <= CW'(DEPTH));
    a_drop_le_out: assert property (@(posedge clk) disable iff (rst) drop_q <= out_q);
    a_no_orphan  : assert property (@(posedge clk) disable iff (rst)
                                    !(mem_rvalid && out_q == '0));
    a_fifo_room  : assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_lanzones_fetch.sv
// Bench for lanzones_fetch: bus responder plus an in-flight/delivery reference model.
module tb_lanzones_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        redir;
    logic [31:0] redir_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        RVld;
    logic [31:0] RData;
    logic [31:0] RPc;
    logic        RRdy;
    logic        busy;

    lanzones_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .redir      (redir),
        .redir_pc   (redir_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .RVld       (RVld),
        .RData      (RData),
        .RPc        (RPc),
        .RRdy       (RRdy),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } bus_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    bus_t        bus_q[$];      // granted requests awaiting their response
    bit          infl[$];       // per in-flight request: still wanted by the core?
    ent_t        exp_q[$];      // words the core should see, in order
    logic [31:0] grant_log[$];
    logic [31:0] pop_log[$];

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned cyc      = 0;
    int          gnt_pct  = 100;
    int          rrdy_pct = 100;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;
    int          n_pops   = 0;
    bit          m_pend;
    bit          m_pend_live;
    logic [31:0] m_pend_addr;
    logic [31:0] m_next;
    logic        last_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; redir = 1'b0; redir_pc = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; RRdy = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_rvld", RVld, 1'b0);
        check("rst_rdata", RData, 32'h0);
        check("rst_rpc", RPc, 32'h0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        bus_q.delete(); infl.delete(); exp_q.delete();
        grant_log.delete(); pop_log.delete();
        m_pend = 1'b0; m_pend_live = 1'b0; m_next = RESET_PC;
        cyc++;
    endtask

    // One clock cycle: drive inputs, check the request side, clock, update model, check outputs.
    task automatic step(input logic e, input logic rd, input logic [31:0] rpc);
        logic        req, gnt_s, rv_s, rrdy_s, live;
        logic [31:0] addr, rsp_addr;
        en = e; redir = rd; redir_pc = rpc;
        mem_gnt = ($urandom_range(99) < gnt_pct);
        if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = bus_q[0].addr ^ 32'hA5A5_0000;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        RRdy = ($urandom_range(99) < rrdy_pct);
        #3;
        req = mem_req; addr = mem_addr; gnt_s = mem_gnt; rv_s = mem_rvalid; rrdy_s = RRdy;
        if (m_pend) begin
            check("req_hold", req, 1'b1);
            check("addr_hold", addr, m_pend_addr);
        end else begin
            check("req_gate", req & ~e, 1'b0);
            if (req) check("req_addr", addr, m_next);
        end
        last_req = req;
        @(posedge clk);
        if (exp_q.size() > 0 && rrdy_s && !rd) begin
            pop_log.push_back(exp_q[0].pc);
            void'(exp_q.pop_front());
            n_pops++;
        end
        if (rv_s && infl.size() > 0) begin
            rsp_addr = bus_q[0].addr;
            live = infl.pop_front();
            void'(bus_q.pop_front());
            if (live && !rd) exp_q.push_back('{pc: rsp_addr, data: rsp_addr ^ 32'hA5A5_0000});
        end
        if (req && !m_pend) begin
            m_pend = 1'b1; m_pend_live = 1'b1; m_pend_addr = m_next; m_next = m_next + 32'd4;
        end
        if (req && gnt_s) begin
            bus_q.push_back('{addr: m_pend_addr, due: cyc + $urandom_range(lat_max, lat_min)});
            infl.push_back(m_pend_live);
            grant_log.push_back(m_pend_addr);
            m_pend = 1'b0;
        end
        if (rd) begin
            exp_q.delete();
            foreach (infl[i]) infl[i] = 1'b0;
            m_pend_live = 1'b0;
            m_next = {rpc[31:2], 2'b00};
        end
        cyc++;
        #1;
        check("rvld", RVld, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("rpc", RPc, exp_q[0].pc);
            check("rdata", RData, exp_q[0].data);
        end
        check("busy", busy, infl.size() != 0);
        check("credit", (exp_q.size() + infl.size()) <= DEPTH, 1'b1);
    endtask

    initial begin
        int  p0;
        bit  rd;
        logic e;

        // Streaming at full rate.
        do_reset();
        gnt_pct = 100; rrdy_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, '0);
        p0 = n_pops;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, '0);
        check("t1_throughput", n_pops - p0, 16);

        // Backpressure: credit stops requests at DEPTH.
        do_reset();
        rrdy_pct = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
        check("t2_grants", grant_log.size(), DEPTH);
        check("t2_last_addr", (grant_log.size() == DEPTH) ? grant_log[DEPTH-1] : 32'hDEAD_BEEF,
              32'h0000_000C);
        check("t2_req_low", mem_req, 1'b0);
        check("t2_full_head", RPc, 32'h0);
        rrdy_pct = 100;
        for (int i = 0; i < 10 && grant_log.size() < 5; i++) step(1'b1, 1'b0, '0);
        check("t2_resume_addr", (grant_log.size() > 4) ? grant_log[4] : 32'hDEAD_BEEF,
              32'h0000_0010);

        // Redirect with three requests in flight.
        do_reset();
        lat_min = 10; lat_max = 10;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
        check("t3_outstanding", grant_log.size(), 3);
        gnt_pct = 0;
        step(1'b0, 1'b1, 32'h0000_0100);
        check("t3_busy", busy, 1'b1);
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 40 && !RVld; i++) step(1'b1, 1'b0, '0);
        check("t3_rvld", RVld, 1'b1);
        check("t3_rpc", RPc, 32'h0000_0100);
        check("t3_rdata", RData, 32'h0000_0100 ^ 32'hA5A5_0000);

        // Redirect coinciding with a grant and a response.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0203);
        check("t4_req_at_redir", last_req, 1'b1);
        for (int i = 0; i < 20 && !RVld; i++) step(1'b1, 1'b0, '0);
        check("t4_rvld", RVld, 1'b1);
        check("t4_rpc", RPc, 32'h0000_0200);

        // Address wrap at the top of memory.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        grant_log.delete(); pop_log.delete();
        for (int i = 0; i < 30 && pop_log.size() < 3; i++) step(1'b1, 1'b0, '0);
        check("t5_pops", pop_log.size() >= 3, 1'b1);
        if (pop_log.size() >= 3) begin
            check("t5_pop0", pop_log[0], 32'hFFFF_FFF8);
            check("t5_pop1", pop_log[1], 32'hFFFF_FFFC);
            check("t5_pop2", pop_log[2], 32'h0000_0000);
        end
        check("t5_gnt_wrap", (grant_log.size() >= 3) ? grant_log[2] : 32'hDEAD_BEEF, 32'h0);

        // Randomized traffic with enable toggling and redirects.
        gnt_pct = 70; rrdy_pct = 70; lat_min = 1; lat_max = 4;
        e = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 4) e = ~e;
            rd = ($urandom_range(99) < 3);
            step(e, rd, $urandom & 32'h0000_3FFF);
        end

        // Reset in the middle of traffic.
        gnt_pct = 100; rrdy_pct = 0; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40 && !(exp_q.size() >= 2 && infl.size() >= 1); i++)
            step(1'b1, 1'b0, '0);
        check("t6_setup", (exp_q.size() >= 2) && (infl.size() >= 1), 1'b1);
        do_reset();
        step(1'b0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
